// File: rtl/prbs_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_chk_pkg
//  Purpose  : Shared PRBS7 constants and checker FSM state type.
//  Revision : 1.0 - initial release
// ============================================================================
package prbs_chk_pkg;

   localparam int c_prbs_order = 7;
   localparam int c_tap_hi     = 6;
   localparam int c_tap_lo     = 5;
   localparam int c_seed_len   = 7;
   localparam int c_seed_cnt_w = $clog2(c_seed_len);

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } chk_state_e;

endpackage
`default_nettype wire

// File: rtl/prbs7_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : prbs7_lfsr
//  Purpose  : PRBS7 (x^7+x^6+1) next-bit prediction and left-shift step.
//  Revision : 1.0 - initial release
// ============================================================================
module prbs7_lfsr
   import prbs_chk_pkg::*;
(
   input  logic [c_prbs_order-1:0] state_i,
   input  logic                    load_bit_i,
   input  logic                    load_sel_i,
   output logic [c_prbs_order-1:0] next_state_o,
   output logic                    pred_bit_o
);

   assign pred_bit_o   = state_i[c_tap_hi] ^ state_i[c_tap_lo];
   // Seeding shifts in the captured bit; otherwise the register free-runs.
   assign next_state_o = {state_i[c_prbs_order-2:0], (load_sel_i ? load_bit_i : pred_bit_o)};

endmodule
`default_nettype wire

// File: rtl/prbs_capture_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_capture_checker
//  Purpose  : Self-synchronising PRBS7 checker with lock detect and error count.
//             Optional macro PRBS_CHK_BITCNT_EN adds bit_count (bits checked).
//  Revision : 1.0 - initial release
// ============================================================================
module prbs_capture_checker
   import prbs_chk_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int LOCK_MATCHES = 16,
   parameter int LOSS_ERRS    = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             valid,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
   ,
   output logic [31:0]      bit_count
`endif
);

   localparam int c_match_w = $clog2(LOCK_MATCHES + 1);
   localparam int c_miss_w  = $clog2(LOSS_ERRS + 1);

   chk_state_e                state_q,     state_d;
   logic [c_prbs_order-1:0]   lfsr_q,      lfsr_d;
   logic [c_seed_cnt_w-1:0]   seed_cnt_q,  seed_cnt_d;
   logic [c_match_w-1:0]      match_cnt_q, match_cnt_d;
   logic [c_miss_w-1:0]       miss_cnt_q,  miss_cnt_d;
   logic [CNT_W-1:0]          err_count_q, err_count_d;
   logic                      err_q,       err_d;

   logic [c_prbs_order-1:0]   w_lfsr_next;
   logic                      w_pred;
   logic                      w_load_sel;
   logic                      w_mismatch;

   assign w_load_sel = (state_q == ST_SEED);
   assign w_mismatch = (din != w_pred);

   prbs7_lfsr u_lfsr (
      .state_i      (lfsr_q),
      .load_bit_i   (din),
      .load_sel_i   (w_load_sel),
      .next_state_o (w_lfsr_next),
      .pred_bit_o   (w_pred)
   );

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_count_d = err_count_q;
      err_d       = 1'b0;

      if (valid) begin
         lfsr_d = w_lfsr_next;
         case (state_q)
            ST_SEED: begin
               if (seed_cnt_q == c_seed_cnt_w'(c_seed_len - 1)) begin
                  seed_cnt_d = '0;
                  // An all-zero register would predict zeros forever; reseed instead.
                  if (w_lfsr_next != '0) begin
                     state_d     = ST_VERIFY;
                     match_cnt_d = '0;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + c_seed_cnt_w'(1);
               end
            end

            ST_VERIFY: begin
               if (w_mismatch) begin
                  state_d    = ST_SEED;
                  seed_cnt_d = '0;
               end else if (match_cnt_q == c_match_w'(LOCK_MATCHES - 1)) begin
                  state_d     = ST_LOCKED;
                  match_cnt_d = '0;
                  miss_cnt_d  = '0;
               end else begin
                  match_cnt_d = match_cnt_q + c_match_w'(1);
               end
            end

            ST_LOCKED: begin
               if (w_mismatch) begin
                  err_d = 1'b1;
                  if (err_count_q != {CNT_W{1'b1}}) begin
                     err_count_d = err_count_q + CNT_W'(1);
                  end
                  if (miss_cnt_q == c_miss_w'(LOSS_ERRS - 1)) begin
                     state_d    = ST_SEED;
                     seed_cnt_d = '0;
                     miss_cnt_d = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + c_miss_w'(1);
                  end
               end else begin
                  miss_cnt_d = '0;
               end
            end

            default: begin
               state_d    = ST_SEED;
               seed_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SEED;
         lfsr_q      <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_count_q <= err_count_d;
         err_q       <= err_d;
      end
   end

   assign locked    = (state_q == ST_LOCKED);
   assign err       = err_q;
   assign err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
   logic [31:0] bit_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_count_q <= '0;
      end else if (valid && (state_q == ST_LOCKED) && (bit_count_q != 32'hFFFF_FFFF)) begin
         bit_count_q <= bit_count_q + 32'd1;
      end
   end

   assign bit_count = bit_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/prbs_capture_checker.md
PRBS_CAPTURE_CHECKER -- requirements
Module: prbs_capture_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, the width of the error counter.
REQ-002 The block SHALL have parameter LOCK_MATCHES, default 16, the number of consecutive matches needed to declare lock.
REQ-003 The block SHALL have parameter LOSS_ERRS, default 4, the number of consecutive mismatches that drops lock.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port din, input, 1: captured serial data bit from the launch-side path under test.
REQ-007 Port valid, input, 1: din is meaningful this cycle; no state advances when low.
REQ-008 Port locked, output, 1: high while the checker is in state LOCKED.
REQ-009 Port err, output, 1: one-cycle pulse on each mismatch counted in LOCKED.
REQ-010 Port err_count, output, CNT_W: saturating count of mismatches seen while LOCKED.

Function
REQ-011 Reference sequence SHALL be PRBS7, x^7+x^6+1; next bit = s[6]^s[5]; the state shifts left with the new bit entering s[0].
REQ-012 The FSM SHALL have states SEED, VERIFY and LOCKED; reset state is SEED.
REQ-013 SEED: each valid din SHALL shift into the LFSR; after 7 valid bits the FSM SHALL go to VERIFY with the match counter at 0.
REQ-014 VERIFY: each valid cycle compares din with the predicted bit and then advances the LFSR with the predicted bit; a match increments the match counter; a mismatch returns the FSM to SEED with the seed counter at 0.
REQ-015 VERIFY to LOCKED SHALL occur on the cycle the LOCK_MATCHES-th consecutive match is registered; locked rises the next cycle (1-cycle latency).
REQ-016 LOCKED: the LFSR SHALL self-advance on every valid cycle, independent of din.
REQ-017 LOCKED: a mismatch SHALL pulse err in the following cycle, increment err_count (saturating at 2^CNT_W-1, no wrap), and increment the consecutive-mismatch counter; a match clears that counter.
REQ-018 When the consecutive-mismatch counter reaches LOSS_ERRS, the FSM SHALL go to SEED; err_count SHALL be retained; locked falls the next cycle.
REQ-019 An all-zero LFSR state SHALL never be used for checking: if SEED completes with s==0, the FSM SHALL stay in SEED and restart seeding.
REQ-020 valid low SHALL freeze all counters, the LFSR and the FSM, and err SHALL be 0.

Reset
REQ-021 rst high SHALL, on the next edge, set FSM=SEED, LFSR=0, all internal counters=0, locked=0, err=0, err_count=0.
REQ-022 rst SHALL take priority over valid in every state, including mid-VERIFY and while LOCKED.

Configuration
REQ-023 Macro PRBS_CHK_BITCNT_EN, when defined, SHALL add output bit_count [31:0]: the number of valid cycles checked in LOCKED, saturating, and cleared only by rst.
REQ-024 Without PRBS_CHK_BITCNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 Shared package prbs_chk_pkg SHALL hold the FSM state enum, PRBS7 order (7), tap positions (6, 5) and the seed-length constant.
REQ-026 The next-bit/shift function SHALL be a sub-module prbs7_lfsr (inputs: state, load bit, load select; outputs: next state, predicted bit), instantiated once.

Verification
REQ-027 Reset, then a clean PRBS7 stream from seed 7'h01 with valid always high -> locked=1 on cycle 7+16+1 after the first valid, and err_count=0 after 1000 bits.
REQ-028 Locked, then one bit of din flipped -> exactly one err pulse, err_count=1, locked stays 1.
REQ-029 Locked, then 4 consecutive flipped bits -> err_count=4, locked falls the cycle after the 4th; the clean stream relocks after 23 further valid bits.
REQ-030 din held 0 for 7 valid bits -> all-zero seed rejected, FSM remains SEED, locked=0 indefinitely.
REQ-031 CNT_W=4 with continuous mismatches, LOSS_ERRS large -> err_count saturates at 15 and does not wrap.
REQ-032 valid toggled 50% on a clean stream, and rst asserted mid-LOCKED -> lock reached after 23 valid bits; rst clears all outputs next edge; with PRBS_CHK_BITCNT_EN, bit_count equals the count of valid cycles in LOCKED.
